// File: rtl/motor_phase_pkg.sv
// Shared types and constants for the motor phase bank.
package motor_phase_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } ch_state_t;

    localparam int DCNT_W = 8;

endpackage

// File: rtl/motor_phase_channel.sv
// One motor phase channel: pending register, dead-time FSM and applied outputs.
module motor_phase_channel
    import motor_phase_pkg::*;
#(
    parameter int CUR_W    = 2,
    parameter int DEADTIME = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic [CUR_W-1:0] shadow_cur,
    input  logic             shadow_phase,
    output logic [CUR_W-1:0] cur_out,
    output logic             phase_out,
    output logic             busy
);

    localparam logic [DCNT_W-1:0] DEAD_LOAD = (DEADTIME > 0) ? DCNT_W'(DEADTIME - 1) : '0;

    ch_state_t         state, state_nxt;
    logic [DCNT_W-1:0] cnt, cnt_nxt;
    logic [CUR_W-1:0]  pend_cur, cur_nxt;
    logic              pend_phase, phase_nxt;
    logic              apply_req;

    // Pending capture; apply_req delays the commit so the FSM acts one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cur   <= '0;
            pend_phase <= 1'b0;
            apply_req  <= 1'b0;
        end else begin
            apply_req <= commit;
            if (commit) begin
                pend_cur   <= shadow_cur;
                pend_phase <= shadow_phase;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_out   <= '0;
            phase_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_out   <= cur_nxt;
            phase_out <= phase_nxt;
        end
    end

    // A commit arriving while DEAD only refreshes pending; exit applies the latest one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur_out;
        phase_nxt = phase_out;
        case (state)
            IDLE: begin
                if (apply_req) begin
                    if ((pend_phase == phase_out) || (DEADTIME == 0)) begin
                        cur_nxt   = pend_cur;
                        phase_nxt = pend_phase;
                    end else begin
                        state_nxt = DEAD;
                        cnt_nxt   = DEAD_LOAD;
                        cur_nxt   = '0;
                    end
                end
            end
            DEAD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cur_nxt   = pend_cur;
                    phase_nxt = pend_phase;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == DEAD);

endmodule

// File: rtl/motor_phase_bank.sv
// Bank of motor phase channels: address decode, shadow registers, per-channel sequencers.
module motor_phase_bank
    import motor_phase_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CUR_W     = 2,
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 0,
    parameter int DEADTIME  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       addr_bus,
    input  logic                    wr_en,
    input  logic [CUR_W-1:0]        cur_bus,
    input  logic                    phase_bus,
    input  logic                    commit,
    output logic [NUM_CH*CUR_W-1:0] cur_out,
    output logic [NUM_CH-1:0]       phase_out,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CUR_W-1:0] shadow_cur;
        logic             shadow_phase;
        logic             wr_sel;

        // Exact-match decode: any address outside the bank selects no channel.
        assign wr_sel = wr_en && (32'(addr_bus) == 32'(BASE_ADDR + n));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_cur   <= '0;
                shadow_phase <= 1'b0;
            end else if (wr_sel) begin
                shadow_cur   <= cur_bus;
                shadow_phase <= phase_bus;
            end
        end

        motor_phase_channel #(
            .CUR_W    (CUR_W),
            .DEADTIME (DEADTIME)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .commit       (commit),
            .shadow_cur   (shadow_cur),
            .shadow_phase (shadow_phase),
            .cur_out      (cur_out[n*CUR_W +: CUR_W]),
            .phase_out    (phase_out[n]),
            .busy         (busy[n])
        );
    end

endmodule

// File: tb/tb_motor_phase_bank.sv
// Directed bench for motor_phase_bank with a timestamp-based reference model.
module tb_motor_phase_bank;

    localparam int NUM_CH    = 4;
    localparam int CUR_W     = 2;
    localparam int ADDR_W    = 5;
    localparam int BASE_ADDR = 0;
    localparam int DEADTIME  = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [ADDR_W-1:0]       addr_bus = '0;
    logic                    wr_en = 1'b0;
    logic [CUR_W-1:0]        cur_bus = '0;
    logic                    phase_bus = 1'b0;
    logic                    commit = 1'b0;
    logic [NUM_CH*CUR_W-1:0] cur_out;
    logic [NUM_CH-1:0]       phase_out;
    logic [NUM_CH-1:0]       busy;

    int checks = 0;
    int errors = 0;

    motor_phase_bank #(
        .NUM_CH(NUM_CH), .CUR_W(CUR_W), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE_ADDR), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .wr_en(wr_en),
        .cur_bus(cur_bus), .phase_bus(phase_bus), .commit(commit),
        .cur_out(cur_out), .phase_out(phase_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: absolute edge count t; a reversal ends at edge dead_end.
    int t = 0;
    int sh_cur[NUM_CH], sh_ph[NUM_CH], pd_cur[NUM_CH], pd_ph[NUM_CH];
    int m_cur[NUM_CH], m_ph[NUM_CH], dead_end[NUM_CH], act[NUM_CH];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            sh_cur[c] = 0; sh_ph[c] = 0; pd_cur[c] = 0; pd_ph[c] = 0;
            m_cur[c] = 0; m_ph[c] = 0; dead_end[c] = -1; act[c] = 0;
        end
    endtask

    task automatic model_edge();
        t++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (dead_end[c] >= 0) begin
                if (t == dead_end[c]) begin
                    m_cur[c] = pd_cur[c]; m_ph[c] = pd_ph[c]; dead_end[c] = -1;
                end
            end else if (act[c] != 0) begin
                if (pd_ph[c] == m_ph[c] || DEADTIME == 0) begin
                    m_cur[c] = pd_cur[c]; m_ph[c] = pd_ph[c];
                end else begin
                    dead_end[c] = t + DEADTIME; m_cur[c] = 0;
                end
            end
            act[c] = int'(commit);
            if (commit) begin
                pd_cur[c] = sh_cur[c]; pd_ph[c] = sh_ph[c];
            end
            if (wr_en && (int'(addr_bus) - BASE_ADDR == c)) begin
                sh_cur[c] = int'(cur_bus); sh_ph[c] = int'(phase_bus);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act_v, exp_v, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [NUM_CH*CUR_W-1:0] e_cur;
        logic [NUM_CH-1:0]       e_ph, e_busy;
        for (int c = 0; c < NUM_CH; c++) begin
            e_cur[c*CUR_W +: CUR_W] = CUR_W'(m_cur[c]);
            e_ph[c]   = (m_ph[c] != 0);
            e_busy[c] = (dead_end[c] >= 0);
        end
        chk("model_cur_out", 32'(cur_out), 32'(e_cur));
        chk("model_phase_out", 32'(phase_out), 32'(e_ph));
        chk("model_busy", 32'(busy), 32'(e_busy));
    end

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic write(input int a, input int c, input int p);
        addr_bus = ADDR_W'(a); cur_bus = CUR_W'(c); phase_bus = p[0]; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
    endtask

    function automatic int ch_cur(input int c);
        return int'(cur_out[c*CUR_W +: CUR_W]);
    endfunction

    initial begin
        int n;
        model_reset();
        assert_reset();
        repeat (3) step();
        chk("reset_cur", 32'(cur_out), 32'h0);
        chk("reset_phase", 32'(phase_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // Single channel, same phase: applied one edge after the commit edge.
        write(2, 3, 0);
        do_commit();
        chk("ch2_not_yet", 32'(cur_out), 32'h0);
        step();
        chk("ch2_applied", 32'(cur_out), 32'h30);
        chk("ch2_phase_busy", 32'({phase_out, busy}), 32'h0);

        // Phase reversal on ch0 with dead time.
        write(0, 2, 0);
        do_commit();
        step();
        chk("ch0_setup", 32'(cur_out), 32'h32);
        write(0, 1, 1);
        do_commit();
        step();
        chk("ch0_dead_cur", 32'(ch_cur(0)), 32'd0);
        chk("ch0_dead_phase", 32'(phase_out[0]), 32'd0);
        n = 0;
        while (busy[0] && n < 20) begin
            n++;
            step();
        end
        chk("ch0_dead_len", 32'(n), 32'd8);
        chk("ch0_exit_phase", 32'(phase_out[0]), 32'd1);
        chk("ch0_exit_cur", 32'(ch_cur(0)), 32'd1);

        // Out-of-range write must not touch anything.
        write(4, 3, 1);
        do_commit();
        step();
        step();
        chk("oor_cur", 32'(cur_out), 32'h31);
        chk("oor_phase", 32'(phase_out), 32'h1);
        chk("oor_busy", 32'(busy), 32'h0);

        // Re-commit during dead time on ch1: counter not restarted.
        write(1, 1, 1);
        do_commit();
        step();
        chk("ch1_dead", 32'(busy[1]), 32'd1);
        write(1, 3, 1);
        step();
        step();
        do_commit();
        n = 0;
        while (busy[1] && n < 20) begin
            n++;
            step();
        end
        chk("ch1_remaining", 32'(n), 32'd4);
        chk("ch1_exit_cur", 32'(ch_cur(1)), 32'd3);
        chk("ch1_exit_phase", 32'(phase_out[1]), 32'd1);
        step();
        chk("ch1_stays", 32'(ch_cur(1)), 32'd3);

        // Write and commit sharing a cycle: commit takes pre-write shadow.
        write(3, 1, 0);
        do_commit();
        step();
        chk("ch3_first", 32'(ch_cur(3)), 32'd1);
        addr_bus = 5'd3; cur_bus = 2'd2; phase_bus = 1'b0; wr_en = 1'b1; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        step();
        chk("ch3_pre_write", 32'(ch_cur(3)), 32'd1);
        do_commit();
        step();
        chk("ch3_second", 32'(ch_cur(3)), 32'd2);

        // Reset in the third dead-time cycle of ch0.
        write(0, 3, 0);
        do_commit();
        step();
        step();
        step();
        chk("ch0_dead_again", 32'(busy[0]), 32'd1);
        assert_reset();
        #1;
        chk("rst_imm_cur", 32'(cur_out), 32'h0);
        chk("rst_imm_phase", 32'(phase_out), 32'h0);
        chk("rst_imm_busy", 32'(busy), 32'h0);
        step();
        reset = 1'b0;
        repeat (12) step();
        chk("post_rst_cur", 32'(cur_out), 32'h0);
        chk("post_rst_phase", 32'(phase_out), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // First edge after release accepts a write.
        assert_reset();
        step();
        reset = 1'b0;
        write(1, 2, 0);
        do_commit();
        step();
        chk("first_edge_write", 32'(cur_out), 32'h08);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_phase_bank.md
MOTOR_PHASE_BANK -- requirements
Module: motor_phase_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of motor phase channels (1..32).
REQ-002 The block SHALL have parameter CUR_W, default 2, meaning the current-select width per channel.
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning the address bus width.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, meaning the address of channel 0; channel n sits at BASE_ADDR+n.
REQ-005 The block SHALL have parameter DEADTIME, default 8, meaning the zero-current cycles inserted on a phase reversal (0..255).
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 addr_bus  input  ADDR_W  write address.
REQ-009 wr_en  input  1  write strobe, one cycle per write.
REQ-010 cur_bus  input  CUR_W  current value to write.
REQ-011 phase_bus  input  1  phase polarity to write.
REQ-012 commit  input  1  single-cycle pulse; transfers all shadow registers to the channel sequencers together.
REQ-013 cur_out  output  NUM_CH*CUR_W  applied current, channel n at bits [n*CUR_W +: CUR_W].
REQ-014 phase_out  output  NUM_CH  applied phase polarity per channel.
REQ-015 busy  output  NUM_CH  high while a channel is in dead time.

Function
REQ-016 Write: wr_en=1 with addr_bus in [BASE_ADDR, BASE_ADDR+NUM_CH) SHALL load {cur_bus, phase_bus} into that channel's shadow register at the next edge.
REQ-017 Writes to out-of-range addresses SHALL be ignored with no side effect.
REQ-018 Shadow writes SHALL NOT affect outputs until commit.
REQ-019 On commit, every channel SHALL copy its shadow into its pending register; when write and commit share a cycle, commit SHALL take the pre-write shadow value.
REQ-020 Channel FSM SHALL have states IDLE and DEAD.
REQ-021 IDLE + commit with pending phase equal to phase_out: cur_out SHALL take the pending current one cycle after the commit edge; FSM stays IDLE.
REQ-022 IDLE + commit with pending phase different and DEADTIME>0: enter DEAD; cur_out SHALL be 0 and busy SHALL be 1 from the next edge; phase_out holds its old value.
REQ-023 DEAD SHALL last exactly DEADTIME cycles (busy high DEADTIME cycles); on exit cur_out and phase_out SHALL update together to pending, busy falls, FSM returns to IDLE.
REQ-024 DEADTIME=0: phase reversal SHALL behave as REQ-021 with phase_out and cur_out updating in the same cycle.
REQ-025 Commit during DEAD SHALL update pending without restarting the counter; exit applies the latest pending, even if its phase equals the old phase.
REQ-026 Channels SHALL sequence independently; one commit may put some channels in DEAD and update others immediately.
REQ-027 The dead-time counter SHALL be 8 bits and SHALL count down from DEADTIME-1 to 0 with no wrap.

Reset
REQ-028 Reset asserted SHALL immediately clear all shadow, pending and applied registers: cur_out=0, phase_out=0, busy=0, all FSMs IDLE, counters 0.
REQ-029 Reset during DEAD SHALL abort the dead time with no pending value applied after release.
REQ-030 The first clock edge after reset deassertion SHALL accept writes and commits normally.

Structure
REQ-031 Package motor_phase_pkg SHALL hold the channel state enum (IDLE, DEAD) and the dead-time counter width constant (8).
REQ-032 Per-channel logic (pending register, FSM, counter, output regs) SHALL be sub-module motor_phase_channel, instantiated NUM_CH times by generate; the top level holds address decode and shadow registers.

Verification
REQ-033 Reset, write addr 2 cur=3 phase=0, commit -> one cycle later cur_out[ch2]=3, phase_out[2]=0, busy=0; other channels 0.
REQ-034 Ch0 applied phase=0 cur=2; write phase=1 cur=1, commit -> cur_out[ch0]=0, busy[0]=1 for exactly 8 cycles, then phase_out[0]=1, cur_out[ch0]=1 on the same edge.
REQ-035 Write addr 4 with NUM_CH=4, BASE_ADDR=0, then commit -> no output or shadow change.
REQ-036 Commit of phase=1 cur=1 to ch1, then commit of phase=1 cur=3 during cycle 4 of DEAD -> DEAD ends at cycle 8, applied cur=3.
REQ-037 Write and commit in the same cycle to ch3 (shadow cur=1, written value cur=2) -> cur_out[ch3]=1; a second commit -> 2.
REQ-038 Assert reset in cycle 3 of DEAD on ch0 -> outputs 0 immediately, busy[0]=0, and nothing applied after release.
